// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch controller.
//   CPU_WIDTH   : architectural address width
//   InstNop     : encoding of addi x0, x0, 0, used as the IF/ID reset value
//   if_state_e  : fetch FSM states
//   align_word  : forces the two low address bits to zero
package if_fetch_ctrl_pkg;

  localparam int unsigned CPU_WIDTH = 32;

  localparam logic [31:0] InstNop = 32'h0000_0013;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StReq  = 2'd1,
    StHold = 2'd2
  } if_state_e;

  // Masking (rather than slicing) keeps every input bit referenced.
  function automatic logic [CPU_WIDTH-1:0] align_word(input logic [CPU_WIDTH-1:0] addr);
    return addr & ~CPU_WIDTH'(3);
  endfunction

endpackage

// File: rtl/if_skid_buf.sv
// One-entry {pc, inst} holding register used when an instruction returns from memory while the
// IF/ID buffer cannot accept it.
//   clk, rst  : clock, synchronous active-high reset
//   load_i    : capture pc_i/inst_i
//   pop_i     : entry consumed by the IF/ID buffer
//   flush_i   : discard entry (redirect); wins over load and pop
//   valid_o, pc_o, inst_o : stored entry
module if_skid_buf
  import if_fetch_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load_i,
  input  logic                 pop_i,
  input  logic                 flush_i,
  input  logic [CPU_WIDTH-1:0] pc_i,
  input  logic [31:0]          inst_i,
  output logic                 valid_o,
  output logic [CPU_WIDTH-1:0] pc_o,
  output logic [31:0]          inst_o
);

  logic                 valid_q, valid_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic [31:0]          inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      inst_d  = inst_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= InstNop;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/if_fetch_ctrl.sv
// Instruction-fetch controller. Holds the fetch PC, keeps one instruction-memory request in
// flight over a req/ack handshake and delivers instructions to ID through a one-entry IF/ID
// buffer backed by a one-entry skid. pc_add4 feeds pc_mux; pc_nxt (its result) is loaded on every
// sequential advance or redirect, with the two low bits forced to zero.
//   clk, rst            : clock, synchronous active-high reset
//   pc_nxt, redirect    : pc_mux result and taken-branch indication
//   pc_add4             : pc + 4 (wrapping), combinational
//   imem_req/addr/ack/rdata : instruction-memory handshake
//   if_valid/pc/inst, id_ready : IF/ID buffer towards decode
// Optional build macro IF_MISALIGN_CHECK_EN adds fetch_misalign, a sticky flag set whenever a
// loaded pc_nxt has non-zero low bits; it is cleared only by rst.
module if_fetch_ctrl
  import if_fetch_ctrl_pkg::*;
#(
  parameter logic [CPU_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [CPU_WIDTH-1:0] pc_nxt,
  input  logic                 redirect,
  output logic [CPU_WIDTH-1:0] pc_add4,
  output logic                 imem_req,
  output logic [CPU_WIDTH-1:0] imem_addr,
  input  logic                 imem_ack,
  input  logic [31:0]          imem_rdata,
  output logic                 if_valid,
  output logic [CPU_WIDTH-1:0] if_pc,
  output logic [31:0]          if_inst,
  input  logic                 id_ready
`ifdef IF_MISALIGN_CHECK_EN
  ,
  output logic                 fetch_misalign
`endif
);

  if_state_e            state_q, state_d;
  logic [CPU_WIDTH-1:0] pc_q, pc_d;
  logic [CPU_WIDTH-1:0] req_pc_q, req_pc_d;
  logic                 drop_q, drop_d;
  logic                 buf_valid_q, buf_valid_d;
  logic [CPU_WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic [31:0]          buf_inst_q, buf_inst_d;

  logic                 skid_load, skid_pop, skid_flush, skid_valid;
  logic [CPU_WIDTH-1:0] skid_pc;
  logic [31:0]          skid_inst;

  logic                 xfer, buf_pop, buf_free, pc_load;
  logic [CPU_WIDTH-1:0] pc_nxt_al;

  assign pc_add4   = pc_q + CPU_WIDTH'(4);
  assign imem_req  = (state_q == StReq);
  assign imem_addr = req_pc_q;
  assign xfer      = imem_req & imem_ack;
  assign buf_pop   = buf_valid_q & id_ready;
  assign buf_free  = ~buf_valid_q | id_ready;
  assign pc_nxt_al = align_word(pc_nxt);

  if_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load_i  (skid_load),
    .pop_i   (skid_pop),
    .flush_i (skid_flush),
    .pc_i    (req_pc_q),
    .inst_i  (imem_rdata),
    .valid_o (skid_valid),
    .pc_o    (skid_pc),
    .inst_o  (skid_inst)
  );

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_pc_d    = req_pc_q;
    drop_d      = drop_q;
    buf_valid_d = buf_valid_q;
    buf_pc_d    = buf_pc_q;
    buf_inst_d  = buf_inst_q;
    skid_load   = 1'b0;
    skid_pop    = 1'b0;
    skid_flush  = 1'b0;
    pc_load     = 1'b0;

    // A pop empties the buffer unless a reload below overrides it.
    if (buf_pop) buf_valid_d = 1'b0;

    if (redirect) begin
      pc_load     = 1'b1;
      pc_d        = pc_nxt_al;
      buf_valid_d = 1'b0;
      skid_flush  = 1'b1;
      if (state_q == StReq && !xfer) begin
        // The request cannot be withdrawn; its data is discarded when the ack arrives.
        drop_d = 1'b1;
      end else begin
        drop_d  = 1'b0;
        state_d = StIdle;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          req_pc_d = pc_q;
          state_d  = StReq;
        end
        StReq: begin
          if (xfer) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = StIdle;
            end else begin
              pc_load = 1'b1;
              pc_d    = pc_nxt_al;
              if (buf_free) begin
                buf_valid_d = 1'b1;
                buf_pc_d    = req_pc_q;
                buf_inst_d  = imem_rdata;
                req_pc_d    = pc_nxt_al;
              end else begin
                skid_load = 1'b1;
                state_d   = StHold;
              end
            end
          end
        end
        StHold: begin
          // Buffer is full here, so id_ready means it is popped and reloaded from the skid.
          if (id_ready && skid_valid) begin
            buf_valid_d = 1'b1;
            buf_pc_d    = skid_pc;
            buf_inst_d  = skid_inst;
            skid_pop    = 1'b1;
            req_pc_d    = pc_q;
            state_d     = StReq;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      req_pc_q    <= RESET_PC;
      drop_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      buf_pc_q    <= '0;
      buf_inst_q  <= InstNop;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_pc_q    <= req_pc_d;
      drop_q      <= drop_d;
      buf_valid_q <= buf_valid_d;
      buf_pc_q    <= buf_pc_d;
      buf_inst_q  <= buf_inst_d;
    end
  end

  assign if_valid = buf_valid_q;
  assign if_pc    = buf_pc_q;
  assign if_inst  = buf_inst_q;

`ifdef IF_MISALIGN_CHECK_EN
  logic misalign_q, misalign_d;

  assign misalign_d = misalign_q | (pc_load & (|pc_nxt[1:0]));

  always_ff @(posedge clk) begin
    if (rst) misalign_q <= 1'b0;
    else     misalign_q <= misalign_d;
  end

  assign fetch_misalign = misalign_q;
`else
  logic unused_pc_load;
  assign unused_pc_load = pc_load;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl. The bench plays pc_mux (pc_nxt = redirect ? target : pc_add4)
// and a memory whose data word is 0xA000_0000 | address, acking whenever ack_en is set.
// Inputs change 1 ns after the rising edge; outputs are checked at that point.
module tb_if_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_nxt;
  logic        redirect;
  logic [31:0] pc_add4;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        id_ready;
`ifdef IF_MISALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  logic        ack_en;
  logic [31:0] target;
  int          checks   = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  assign pc_nxt     = redirect ? target : pc_add4;
  assign imem_ack   = imem_req & ack_en;
  assign imem_rdata = 32'hA000_0000 | imem_addr;

  if_fetch_ctrl #(
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_nxt     (pc_nxt),
    .redirect   (redirect),
    .pc_add4    (pc_add4),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .if_valid   (if_valid),
    .if_pc      (if_pc),
    .if_inst    (if_inst),
    .id_ready   (id_ready)
`ifdef IF_MISALIGN_CHECK_EN
    ,
    .fetch_misalign (fetch_misalign)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles, then release; the next edge issues the first request.
  task automatic do_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    target   = 32'h0;
    ack_en   = 1'b1;
    id_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    redirect = 1'b0;
    target   = 32'h0;
    ack_en   = 1'b1;
    id_ready = 1'b1;
    tick();
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", if_valid); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL reset_if_pc got=%h exp=00000000", if_pc); end
    checks++; if (if_inst !== 32'h0000_0013) begin failures++; $display("FAIL reset_if_inst got=%h exp=00000013", if_inst); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=00000000", imem_addr); end
    checks++; if (pc_add4 !== 32'h4) begin failures++; $display("FAIL reset_pc_add4 got=%h exp=00000004", pc_add4); end
`ifdef IF_MISALIGN_CHECK_EN
    checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL reset_misalign got=%0h exp=0", fetch_misalign); end
`endif
    rst = 1'b0;
  endtask

  // Zero-wait memory, id_ready=1: one request per cycle, buffer one cycle behind.
  task automatic test_stream();
    do_reset();
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL stream_req[%0d] got=%0h exp=1", k, imem_req); end
      checks++; if (imem_addr !== 32'(4 * k)) begin failures++; $display("FAIL stream_addr[%0d] got=%h exp=%h", k, imem_addr, 32'(4 * k)); end
      checks++; if (if_valid !== (k > 0)) begin failures++; $display("FAIL stream_valid[%0d] got=%0h exp=%0h", k, if_valid, (k > 0)); end
      if (k > 0) begin
        checks++; if (if_pc !== 32'(4 * (k - 1))) begin failures++; $display("FAIL stream_if_pc[%0d] got=%h exp=%h", k, if_pc, 32'(4 * (k - 1))); end
        checks++; if (if_inst !== (32'hA000_0000 | 32'(4 * (k - 1)))) begin failures++; $display("FAIL stream_if_inst[%0d] got=%h exp=%h", k, if_inst, 32'hA000_0000 | 32'(4 * (k - 1))); end
      end
    end
  endtask

  // Decode stalls after 0x0 is buffered: 0x4 parks in the skid, fetch pauses, then resumes at 0x8.
  task automatic test_skid();
    do_reset();
    tick();           // request 0x0
    tick();           // 0x0 buffered, request 0x4
    id_ready = 1'b0;
    tick();           // 0x4 acked into the skid
    for (int k = 0; k < 2; k++) begin
      checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL skid_hold_req[%0d] got=%0h exp=0", k, imem_req); end
      checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL skid_hold_valid[%0d] got=%0h exp=1", k, if_valid); end
      checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL skid_hold_if_pc[%0d] got=%h exp=00000000", k, if_pc); end
      tick();
    end
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL skid_hold_req_last got=%0h exp=0", imem_req); end
    id_ready = 1'b1;
    tick();
    checks++; if (if_pc !== 32'h4) begin failures++; $display("FAIL skid_out_if_pc got=%h exp=00000004", if_pc); end
    checks++; if (if_inst !== 32'hA000_0004) begin failures++; $display("FAIL skid_out_if_inst got=%h exp=a0000004", if_inst); end
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL skid_out_valid got=%0h exp=1", if_valid); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL skid_resume_req got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL skid_resume_addr got=%h exp=00000008", imem_addr); end
    tick();
    checks++; if (if_pc !== 32'h8) begin failures++; $display("FAIL skid_next_if_pc got=%h exp=00000008", if_pc); end
  endtask

  // Redirect while 0x8 is outstanding: its ack is dropped, then one IDLE cycle, then 0x100.
  task automatic test_redirect_pending();
    do_reset();
    tick();           // request 0x0
    tick();           // request 0x4
    tick();           // request 0x8, 0x4 buffered
    ack_en   = 1'b0;
    id_ready = 1'b0;
    tick();           // 0x8 pending, 0x4 held
    checks++; if (if_valid !== 1'b1) begin failures++; $display("FAIL rdp_pre_valid got=%0h exp=1", if_valid); end
    redirect = 1'b1;
    target   = 32'h100;
    tick();
    redirect = 1'b0;
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rdp_valid_cleared got=%0h exp=0", if_valid); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rdp_req_kept got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h8) begin failures++; $display("FAIL rdp_addr_kept got=%h exp=00000008", imem_addr); end
    ack_en   = 1'b1;
    id_ready = 1'b1;
    tick();           // dropped ack
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rdp_idle_req got=%0h exp=0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rdp_drop_valid got=%0h exp=0", if_valid); end
    tick();
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rdp_tgt_req got=%0h exp=1", imem_req); end
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL rdp_tgt_addr got=%h exp=00000100", imem_addr); end
    tick();
    checks++; if (if_pc !== 32'h100) begin failures++; $display("FAIL rdp_tgt_if_pc got=%h exp=00000100", if_pc); end
    checks++; if (if_inst !== 32'hA000_0100) begin failures++; $display("FAIL rdp_tgt_if_inst got=%h exp=a0000100", if_inst); end
    checks++; if (imem_addr !== 32'h104) begin failures++; $display("FAIL rdp_next_addr got=%h exp=00000104", imem_addr); end
  endtask

  // Redirect coinciding with the ack of 0x4: data discarded, one IDLE cycle, then 0x200.
  task automatic test_redirect_ack();
    do_reset();
    tick();           // request 0x0
    tick();           // request 0x4, 0x0 buffered
    redirect = 1'b1;
    target   = 32'h200;
    tick();
    redirect = 1'b0;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rda_idle_req got=%0h exp=0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rda_valid got=%0h exp=0", if_valid); end
    tick();
    checks++; if (imem_addr !== 32'h200) begin failures++; $display("FAIL rda_tgt_addr got=%h exp=00000200", imem_addr); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rda_no_stale_valid got=%0h exp=0", if_valid); end
    tick();
    checks++; if (if_pc !== 32'h200) begin failures++; $display("FAIL rda_tgt_if_pc got=%h exp=00000200", if_pc); end
  endtask

  // pc + 4 wraps to zero at the top of the address space.
  task automatic test_wrap();
    do_reset();
    tick();           // request 0x0
    redirect = 1'b1;
    target   = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    tick();
    checks++; if (imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_addr got=%h exp=fffffffc", imem_addr); end
    checks++; if (pc_add4 !== 32'h0) begin failures++; $display("FAIL wrap_pc_add4 got=%h exp=00000000", pc_add4); end
    tick();
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_next_addr got=%h exp=00000000", imem_addr); end
    checks++; if (if_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_if_pc got=%h exp=fffffffc", if_pc); end
  endtask

  // Reset while a request is outstanding and the buffer is full.
  task automatic test_reset_mid();
    do_reset();
    tick();
    tick();           // 0x0 buffered, 0x4 requested
    ack_en = 1'b0;
    rst    = 1'b1;
    tick();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rstmid_req got=%0h exp=0", imem_req); end
    checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0h exp=0", if_valid); end
    checks++; if (if_inst !== 32'h0000_0013) begin failures++; $display("FAIL rstmid_if_inst got=%h exp=00000013", if_inst); end
    checks++; if (if_pc !== 32'h0) begin failures++; $display("FAIL rstmid_if_pc got=%h exp=00000000", if_pc); end
    checks++; if (pc_add4 !== 32'h4) begin failures++; $display("FAIL rstmid_pc_add4 got=%h exp=00000004", pc_add4); end
    rst    = 1'b0;
    ack_en = 1'b1;
    tick();
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL rstmid_restart_addr got=%h exp=00000000", imem_addr); end
    checks++; if (imem_req !== 1'b1) begin failures++; $display("FAIL rstmid_restart_req got=%0h exp=1", imem_req); end
  endtask

`ifdef IF_MISALIGN_CHECK_EN
  task automatic test_misalign();
    do_reset();
    tick();           // request 0x0
    redirect = 1'b1;
    target   = 32'h102;
    tick();
    redirect = 1'b0;
    checks++; if (fetch_misalign !== 1'b1) begin failures++; $display("FAIL mis_set got=%0h exp=1", fetch_misalign); end
    tick();
    checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL mis_addr got=%h exp=00000100", imem_addr); end
    tick();
    tick();
    checks++; if (fetch_misalign !== 1'b1) begin failures++; $display("FAIL mis_sticky got=%0h exp=1", fetch_misalign); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (fetch_misalign !== 1'b0) begin failures++; $display("FAIL mis_clear got=%0h exp=0", fetch_misalign); end
  endtask
`endif

  initial begin
    rst      = 1'b1;
    redirect = 1'b0;
    target   = 32'h0;
    ack_en   = 1'b1;
    id_ready = 1'b1;
    test_reset();
    test_stream();
    test_skid();
    test_redirect_pending();
    test_redirect_ack();
    test_wrap();
    test_reset_mid();
`ifdef IF_MISALIGN_CHECK_EN
    test_misalign();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
